// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: raster counters, strobes, frame count, delayed syncs and blanked colour.
// Optional macro VGA_TIMING_BORDER_EN forces an all-ones one-pixel border around the visible area.
module vga_timing_gen #(
   parameter int   H_ACTIVE    = 800,
   parameter int   H_FRONT     = 40,
   parameter int   H_SYNC      = 128,
   parameter int   H_BACK      = 88,
   parameter int   V_ACTIVE    = 600,
   parameter int   V_FRONT     = 1,
   parameter int   V_SYNC      = 4,
   parameter int   V_BACK      = 23,
   parameter logic H_SYNC_POL  = 1'b1,
   parameter logic V_SYNC_POL  = 1'b1,
   parameter int   PIPE_DELAY  = 2,
   parameter int   COORD_W     = 16,
   parameter int   FRAME_CNT_W = 8
) (
   input  logic                   i_pix_clk,
   input  logic                   i_reset_n,
   output logic [COORD_W-1:0]     o_horz_coord,
   output logic [COORD_W-1:0]     o_vert_coord,
   output logic                   o_in_active_area,
   output logic                   o_line_start,
   output logic                   o_frame_start,
   output logic [FRAME_CNT_W-1:0] o_frame_count,
   input  logic [2:0]             i_red,
   input  logic [2:0]             i_green,
   input  logic [1:0]             i_blue,
   output logic [2:0]             o_red,
   output logic [2:0]             o_green,
   output logic [1:0]             o_blue,
   output logic                   o_horz_sync,
   output logic                   o_vert_sync,
   output logic                   o_video_active
);

   localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
   localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);
   localparam logic [COORD_W-1:0] H_ACT  = COORD_W'(H_ACTIVE);
   localparam logic [COORD_W-1:0] V_ACT  = COORD_W'(V_ACTIVE);
   localparam logic [COORD_W-1:0] HS_BEG = COORD_W'(H_ACTIVE + H_FRONT);
   localparam logic [COORD_W-1:0] HS_END = COORD_W'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [COORD_W-1:0] VS_BEG = COORD_W'(V_ACTIVE + V_FRONT);
   localparam logic [COORD_W-1:0] VS_END = COORD_W'(V_ACTIVE + V_FRONT + V_SYNC);

`ifdef VGA_TIMING_BORDER_EN
   localparam logic [COORD_W-1:0] H_ACT_LAST = COORD_W'(H_ACTIVE - 1);
   localparam logic [COORD_W-1:0] V_ACT_LAST = COORD_W'(V_ACTIVE - 1);
   localparam int DW = 4;
`else
   localparam int DW = 3;
`endif

   // run_q holds the raster at (0,0) for the first edge after reset so that edge presents the frame start
   logic                   run_q, run_d;
   logic [COORD_W-1:0]     x_q, x_d;
   logic [COORD_W-1:0]     y_q, y_d;
   logic                   act_q, act_d;
   logic                   ls_q, ls_d;
   logic                   fs_q, fs_d;
   logic                   hs0_q, hs0_d;
   logic                   vs0_q, vs0_d;
   logic [FRAME_CNT_W-1:0] fc_q, fc_d;
`ifdef VGA_TIMING_BORDER_EN
   logic                   brd_q, brd_d;
`endif

   always_comb begin
      x_d   = '0;
      y_d   = '0;
      run_d = 1'b1;
      if (run_q) begin
         if (x_q == H_LAST) begin
            x_d = '0;
            y_d = (y_q == V_LAST) ? '0 : y_q + COORD_W'(1);
         end else begin
            x_d = x_q + COORD_W'(1);
            y_d = y_q;
         end
      end
      act_d = (x_d < H_ACT) && (y_d < V_ACT);
      ls_d  = (x_d == '0);
      fs_d  = (x_d == '0) && (y_d == '0);
      hs0_d = ((x_d >= HS_BEG) && (x_d < HS_END)) ? H_SYNC_POL : ~H_SYNC_POL;
      vs0_d = ((y_d >= VS_BEG) && (y_d < VS_END)) ? V_SYNC_POL : ~V_SYNC_POL;
      fc_d  = fc_q + FRAME_CNT_W'(fs_q);
`ifdef VGA_TIMING_BORDER_EN
      brd_d = act_d && ((x_d == '0) || (x_d == H_ACT_LAST) ||
                        (y_d == '0) || (y_d == V_ACT_LAST));
`endif
   end

   always_ff @(posedge i_pix_clk) begin
      if (!i_reset_n) begin
         run_q <= 1'b0;
         x_q   <= '0;
         y_q   <= '0;
         act_q <= 1'b0;
         ls_q  <= 1'b0;
         fs_q  <= 1'b0;
         hs0_q <= ~H_SYNC_POL;
         vs0_q <= ~V_SYNC_POL;
         fc_q  <= '0;
`ifdef VGA_TIMING_BORDER_EN
         brd_q <= 1'b0;
`endif
      end else begin
         run_q <= run_d;
         x_q   <= x_d;
         y_q   <= y_d;
         act_q <= act_d;
         ls_q  <= ls_d;
         fs_q  <= fs_d;
         hs0_q <= hs0_d;
         vs0_q <= vs0_d;
         fc_q  <= fc_d;
`ifdef VGA_TIMING_BORDER_EN
         brd_q <= brd_d;
`endif
      end
   end

   assign o_horz_coord     = x_q;
   assign o_vert_coord     = y_q;
   assign o_in_active_area = act_q;
   assign o_line_start     = ls_q;
   assign o_frame_start    = fs_q;
   assign o_frame_count    = fc_q;

   // Delay line bundle: {border (optional), active, vsync, hsync}
   logic [DW-1:0] s0_w;
   logic [DW-1:0] dly_w;
`ifdef VGA_TIMING_BORDER_EN
   localparam logic [DW-1:0] IDLE = {1'b0, 1'b0, ~V_SYNC_POL, ~H_SYNC_POL};
   assign s0_w = {brd_q, act_q, vs0_q, hs0_q};
`else
   localparam logic [DW-1:0] IDLE = {1'b0, ~V_SYNC_POL, ~H_SYNC_POL};
   assign s0_w = {act_q, vs0_q, hs0_q};
`endif

   generate
      if (PIPE_DELAY == 0) begin : g_no_dly
         assign dly_w = s0_w;
      end else begin : g_dly
         logic [DW-1:0] pipe_q [PIPE_DELAY];
         logic [DW-1:0] pipe_d [PIPE_DELAY];

         always_comb begin
            pipe_d[0] = s0_w;
            for (int i = 1; i < PIPE_DELAY; i++) begin
               pipe_d[i] = pipe_q[i-1];
            end
         end

         always_ff @(posedge i_pix_clk) begin
            if (!i_reset_n) begin
               for (int i = 0; i < PIPE_DELAY; i++) begin
                  pipe_q[i] <= IDLE;
               end
            end else begin
               for (int i = 0; i < PIPE_DELAY; i++) begin
                  pipe_q[i] <= pipe_d[i];
               end
            end
         end

         assign dly_w = pipe_q[PIPE_DELAY-1];
      end
   endgenerate

   assign o_horz_sync    = dly_w[0];
   assign o_vert_sync    = dly_w[1];
   assign o_video_active = dly_w[2];

   // Colour arrives PIPE_DELAY cycles after its coordinate, so it lines up with the delayed flags directly
   always_comb begin
      o_red   = '0;
      o_green = '0;
      o_blue  = '0;
      if (dly_w[2]) begin
         o_red   = i_red;
         o_green = i_green;
         o_blue  = i_blue;
      end
`ifdef VGA_TIMING_BORDER_EN
      if (dly_w[3]) begin
         o_red   = '1;
         o_green = '1;
         o_blue  = '1;
      end
`endif
   end

endmodule
